// File: rtl/instr_pkg.sv
// Shared RV32I encoding definitions: instruction formats, major opcodes and
// the load-controller state encoding.
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Major opcodes, instr[6:2]; bits [1:0] are always 2'b11 in RV32I.
  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_IMM      = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // True when v is representable as a two's-complement number of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Host tuple handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_fmt;
  logic [4:0]            in_opcode;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  mem_we;
  logic                  mem_ack;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: decoded fields -> 32-bit word, flagging
// immediates the selected format cannot represent (or an unknown format).
module instr_pack
  import instr_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [4:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        imm_err
);

  logic [6:0] lo;
  logic       is_shift;

  assign lo       = {opcode, 2'b11};
  // slli/srli/srai carry funct7 in the upper bits and a 5-bit shamt.
  assign is_shift = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);

  always_comb begin
    word    = '0;
    imm_err = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, lo};
      FMT_I: begin
        if (is_shift) begin
          word    = {funct7, imm[4:0], rs1, funct3, rd, lo};
          imm_err = |imm[31:5];
        end else begin
          word    = {imm[11:0], rs1, funct3, rd, lo};
          imm_err = !fits_signed(imm, 12);
        end
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], lo};
        imm_err = !fits_signed(imm, 12);
      end
      FMT_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], lo};
        imm_err = imm[0] || !fits_signed(imm, 13);
      end
      FMT_U: begin
        word    = {imm[31:12], rd, lo};
        imm_err = |imm[11:0];
      end
      FMT_J: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, lo};
        imm_err = imm[0] || !fits_signed(imm, 21);
      end
      default: imm_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-load path: accepts field tuples, packs them and writes the words to
// consecutive instruction-memory addresses starting at BASE_ADDR.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_encoder_if.slave        bus,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  full,
  output logic                  err_imm
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic [31:0]           word;
  logic                  imm_err;
  logic                  write_done;
  logic                  last_done;
  logic                  accept;

  instr_pack u_pack (
    .fmt     (bus.in_fmt),
    .opcode  (bus.in_opcode),
    .funct3  (bus.in_funct3),
    .funct7  (bus.in_funct7),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .imm     (bus.in_imm),
    .word    (word),
    .imm_err (imm_err)
  );

  assign write_done = we_q && bus.mem_ack;
  assign last_done  = write_done && (addr_q == LAST_ADDR);

  // The slot frees as the pending write is acked, except on the final ack:
  // the next state is FULL, so nothing more may be taken.
  assign bus.in_ready = (state_q == ST_LOAD) && !start &&
                        (!we_q || (bus.mem_ack && (addr_q != LAST_ADDR)));
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)                                   state_d = ST_LOAD;
    else if ((state_q == ST_LOAD) && last_done)  state_d = ST_FULL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= FIRST_ADDR;
      count_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (start) begin
      addr_q  <= FIRST_ADDR;
      count_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (write_done) begin
        addr_q  <= addr_q + ADDR_WIDTH'(1);
        count_q <= count_q + (ADDR_WIDTH + 1)'(1);
        we_q    <= 1'b0;
      end
      // A rejected tuple still completes its handshake but never reaches memory.
      if (accept) begin
        if (imm_err) begin
          err_q <= 1'b1;
        end else begin
          we_q    <= 1'b1;
          wdata_q <= word;
        end
      end
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign count         = count_q;
  assign busy          = (state_q == ST_LOAD);
  assign full          = (state_q == ST_FULL);
  assign err_imm       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, randomized
// traffic against a behavioural model, FULL/stall and async-reset sequences.
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int M_AW   = 8;
  localparam int M_BASE = 5;
  localparam int M_LAST = 4;
  localparam int M_SIZE = 256;

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } tuple_t;

  typedef struct {
    tuple_t      t;
    logic [31:0] word;
    logic        writes;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_m = 1'b0;
  logic start_s = 1'b0;
  logic [M_AW:0] count_m;
  logic [2:0]    count_s;
  logic busy_m, full_m, err_m, busy_s, full_s, err_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the main DUT: 0 idle, 1 loading, 2 full.
  int          m_state = 0;
  int          m_addr  = M_BASE;
  int          m_count = 0;
  bit          m_pend  = 0;
  bit          m_err   = 0;
  logic [31:0] m_word  = '0;

  instr_encoder_if #(.ADDR_WIDTH(M_AW)) bus ();
  instr_encoder_if #(.ADDR_WIDTH(2))    bus_s ();

  instr_encoder #(.ADDR_WIDTH(M_AW), .BASE_ADDR(M_BASE)) dut (
    .clk(clk), .rst(rst), .start(start_m), .bus(bus),
    .count(count_m), .busy(busy_m), .full(full_m), .err_imm(err_m)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .bus(bus_s),
    .count(count_s), .busy(busy_s), .full(full_s), .err_imm(err_s)
  );

  always #5 clk = ~clk;

  function automatic tuple_t mk(logic [2:0] fmt, logic [4:0] op, logic [2:0] f3,
                                logic [6:0] f7, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [31:0] imm);
    tuple_t t;
    t.fmt = fmt; t.op = op; t.f3 = f3; t.f7 = f7;
    t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  // Reference encoding from field positions and signed immediate ranges.
  function automatic void ref_encode(input tuple_t t, output logic [31:0] w, output bit ok);
    int          s;
    logic [31:0] lo, regs;
    s    = t.imm;
    lo   = (32'(t.op) << 2) + 32'd3;
    regs = (32'(t.rs1) << 15) + (32'(t.f3) << 12);
    w  = '0;
    ok = 1'b0;
    case (t.fmt)
      3'd0: begin
        w  = (32'(t.f7) << 25) + (32'(t.rs2) << 20) + regs + (32'(t.rd) << 7) + lo;
        ok = 1'b1;
      end
      3'd1: begin
        if (t.op == OP_IMM && (t.f3 == 3'd1 || t.f3 == 3'd5)) begin
          w  = (32'(t.f7) << 25) + ((t.imm & 32'h1F) << 20) + regs + (32'(t.rd) << 7) + lo;
          ok = (t.imm < 32);
        end else begin
          w  = ((t.imm & 32'hFFF) << 20) + regs + (32'(t.rd) << 7) + lo;
          ok = (s >= -2048) && (s <= 2047);
        end
      end
      3'd2: begin
        w  = (((t.imm >> 5) & 32'h7F) << 25) + (32'(t.rs2) << 20) + regs +
             ((t.imm & 32'h1F) << 7) + lo;
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd3: begin
        w  = (((t.imm >> 12) & 32'h1) << 31) + (((t.imm >> 5) & 32'h3F) << 25) +
             (32'(t.rs2) << 20) + regs + (((t.imm >> 1) & 32'hF) << 8) +
             (((t.imm >> 11) & 32'h1) << 7) + lo;
        ok = (s % 2 == 0) && (s >= -4096) && (s <= 4094);
      end
      3'd4: begin
        w  = (t.imm & 32'hFFFFF000) + (32'(t.rd) << 7) + lo;
        ok = ((t.imm & 32'hFFF) == 0);
      end
      3'd5: begin
        w  = (((t.imm >> 20) & 32'h1) << 31) + (((t.imm >> 1) & 32'h3FF) << 21) +
             (((t.imm >> 11) & 32'h1) << 20) + (((t.imm >> 12) & 32'hFF) << 12) +
             (32'(t.rd) << 7) + lo;
        ok = (s % 2 == 0) && (s >= -1048576) && (s <= 1048574);
      end
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic tuple_t randTuple();
    tuple_t t;
    bit     inrange;
    t.fmt = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    t.op  = 5'($urandom);
    t.f3  = 3'($urandom);
    t.f7  = 7'($urandom);
    t.rd  = 5'($urandom);
    t.rs1 = 5'($urandom);
    t.rs2 = 5'($urandom);
    if (t.fmt == 3'd1 && $urandom_range(0, 1) == 1) t.op = OP_IMM;
    inrange = ($urandom_range(0, 9) < 7);
    t.imm = 32'($urandom);
    if (inrange) begin
      case (t.fmt)
        3'd1: t.imm = (t.op == OP_IMM && t.f3[1:0] == 2'b01) ? 32'($urandom_range(0, 31))
                                                            : 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd2: t.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd3: t.imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
        3'd4: t.imm = 32'($urandom) & 32'hFFFFF000;
        3'd5: t.imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
        default: ;
      endcase
    end
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic driveMain(input tuple_t t);
    bus.in_fmt = t.fmt; bus.in_opcode = t.op; bus.in_funct3 = t.f3; bus.in_funct7 = t.f7;
    bus.in_rd = t.rd; bus.in_rs1 = t.rs1; bus.in_rs2 = t.rs2; bus.in_imm = t.imm;
  endtask

  task automatic driveSmall(input tuple_t t);
    bus_s.in_fmt = t.fmt; bus_s.in_opcode = t.op; bus_s.in_funct3 = t.f3; bus_s.in_funct7 = t.f7;
    bus_s.in_rd = t.rd; bus_s.in_rs1 = t.rs1; bus_s.in_rs2 = t.rs2; bus_s.in_imm = t.imm;
  endtask

  // One cycle on the main DUT: drive, compare against the model, advance the model.
  task automatic applyStimulus(input logic st, input logic vld, input logic ack, input tuple_t t);
    bit          exp_ready;
    bit          ok;
    logic [31:0] w;
    @(negedge clk);
    start_m = st;
    bus.in_valid = vld;
    bus.mem_ack = ack;
    driveMain(t);
    #1;
    checkOutput("busy", 32'(busy_m), 32'(m_state == 1));
    checkOutput("full", 32'(full_m), 32'(m_state == 2));
    checkOutput("count", 32'(count_m), 32'(m_count));
    checkOutput("err_imm", 32'(err_m), 32'(m_err));
    checkOutput("mem_we", 32'(bus.mem_we), 32'(m_pend));
    checkOutput("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    if (m_pend) checkOutput("mem_wdata", bus.mem_wdata, m_word);
    exp_ready = (m_state == 1) && !st && (!m_pend || (ack && m_addr != M_LAST));
    checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    if (st) begin
      m_state = 1; m_addr = M_BASE; m_count = 0; m_err = 0; m_pend = 0;
    end else begin
      if (m_pend && ack) begin
        if (m_addr == M_LAST) m_state = 2;
        m_addr  = (m_addr + 1) % M_SIZE;
        m_count = m_count + 1;
        m_pend  = 0;
      end
      if (vld && exp_ready) begin
        ref_encode(t, w, ok);
        if (ok) begin m_pend = 1; m_word = w; end
        else m_err = 1;
      end
    end
  endtask

  vec_t   vecs[17];
  tuple_t idle_t;
  tuple_t small_t[5];
  logic [31:0] small_w[5];

  initial begin
    int  waddr;
    int  acc, wr;
    bit  ok;
    logic [31:0] w;

    idle_t = mk(3'd0, 5'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    vecs[0]  = '{mk(FMT_I, OP_IMM,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5),        32'h00500093, 1'b1, 1'b0};
    vecs[1]  = '{mk(FMT_R, OP_OP,     3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0),        32'h402081B3, 1'b1, 1'b0};
    vecs[2]  = '{mk(FMT_S, OP_STORE,  3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8),        32'h0020A423, 1'b1, 1'b0};
    vecs[3]  = '{mk(FMT_B, OP_BRANCH, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC), 32'hFE000EE3, 1'b1, 1'b0};
    vecs[4]  = '{mk(FMT_U, OP_LUI,    3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000), 32'h123452B7, 1'b1, 1'b0};
    vecs[5]  = '{mk(FMT_I, OP_IMM,    3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3),        32'h40315093, 1'b1, 1'b0};
    vecs[6]  = '{mk(FMT_J, OP_JAL,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8),        32'h008000EF, 1'b1, 1'b0};
    vecs[7]  = '{mk(FMT_I, OP_LOAD,   3'd2, 7'h00, 5'd3, 5'd2, 5'd0, 32'hFFFFFFFF), 32'hFFF12183, 1'b1, 1'b0};
    vecs[8]  = '{mk(FMT_J, OP_JAL,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3),        32'h0,        1'b0, 1'b1};
    vecs[9]  = '{mk(FMT_I, OP_IMM,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5),        32'h00500093, 1'b1, 1'b1};
    vecs[10] = '{mk(3'd6,  OP_OP,     3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0),        32'h0,        1'b0, 1'b1};
    vecs[11] = '{mk(FMT_I, OP_IMM,    3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd32),       32'h0,        1'b0, 1'b1};
    vecs[12] = '{mk(FMT_I, OP_IMM,    3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048),     32'h0,        1'b0, 1'b1};
    vecs[13] = '{mk(FMT_B, OP_BRANCH, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094),     32'h7E000FE3, 1'b1, 1'b1};
    vecs[14] = '{mk(FMT_U, OP_LUI,    3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h00001001), 32'h0,        1'b0, 1'b1};
    vecs[15] = '{mk(FMT_S, OP_STORE,  3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFF800), 32'h8020A023, 1'b1, 1'b1};
    vecs[16] = '{mk(FMT_J, OP_JAL,    3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFF00000), 32'h8000006F, 1'b1, 1'b1};

    bus.in_valid = 1'b0; bus.mem_ack = 1'b0; driveMain(idle_t);
    bus_s.in_valid = 1'b0; bus_s.mem_ack = 1'b0; driveSmall(idle_t);

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'(M_BASE));
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("rst_count", 32'(count_m), 32'd0);
    checkOutput("rst_busy", 32'(busy_m), 32'd0);
    checkOutput("rst_full", 32'(full_m), 32'd0);
    checkOutput("rst_err", 32'(err_m), 32'd0);
    rst = 1'b0;

    // Tuples are refused while idle, and start beats a simultaneous tuple.
    applyStimulus(1'b0, 1'b1, 1'b1, vecs[0].t);
    applyStimulus(1'b1, 1'b1, 1'b1, vecs[0].t);
    applyStimulus(1'b0, 1'b0, 1'b1, idle_t);

    // Directed vector table; each accepted word must appear one cycle later.
    waddr = M_BASE;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, vecs[i].t);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_we", i), 32'(bus.mem_we), 32'(vecs[i].writes));
      checkOutput($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(waddr));
      checkOutput($sformatf("vec%0d_err", i), 32'(err_m), 32'(vecs[i].err));
      if (vecs[i].writes) begin
        checkOutput($sformatf("vec%0d_wdata", i), bus.mem_wdata, vecs[i].word);
        waddr++;
      end
      applyStimulus(1'b0, 1'b0, 1'b1, idle_t);
    end

    // start clears the sticky error and rewinds the address.
    applyStimulus(1'b1, 1'b0, 1'b0, idle_t);
    @(posedge clk);
    #1;
    checkOutput("start_clears_err", 32'(err_m), 32'd0);
    checkOutput("start_addr", 32'(bus.mem_addr), 32'(M_BASE));
    checkOutput("start_count", 32'(count_m), 32'd0);

    // Randomized traffic with stalls, restarts and wrap into FULL.
    for (int c = 0; c < 1500; c++) begin
      logic st;
      st = ($urandom_range(0, 499) == 0) || (m_state == 2 && $urandom_range(0, 3) == 0);
      applyStimulus(st, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) < 7), randTuple());
    end
    bus.in_valid = 1'b0;
    bus.mem_ack = 1'b0;

    // Small memory: 5 tuples offered, only 4 fit, acks randomly stalled.
    for (int i = 0; i < 5; i++) begin
      small_t[i] = mk(FMT_I, OP_IMM, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3));
      ref_encode(small_t[i], small_w[i], ok);
    end
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    acc = 0;
    wr  = 0;
    for (int c = 0; c < 200 && wr < 4; c++) begin
      @(negedge clk);
      driveSmall(small_t[(acc < 5) ? acc : 4]);
      bus_s.in_valid = 1'b1;
      bus_s.mem_ack = 1'($urandom_range(0, 2) != 0);
      #1;
      if (bus_s.mem_we) begin
        checkOutput("small_addr", 32'(bus_s.mem_addr), 32'(wr));
        checkOutput("small_wdata", bus_s.mem_wdata, small_w[wr]);
        if (bus_s.mem_ack) wr++;
      end
      if (bus_s.in_valid && bus_s.in_ready) acc++;
    end
    checkOutput("small_writes", 32'(wr), 32'd4);
    @(negedge clk);
    bus_s.in_valid = 1'b1;
    bus_s.mem_ack = 1'b1;
    #1;
    checkOutput("small_full", 32'(full_s), 32'd1);
    checkOutput("small_busy", 32'(busy_s), 32'd0);
    checkOutput("small_count", 32'(count_s), 32'd4);
    checkOutput("small_ready", 32'(bus_s.in_ready), 32'd0);
    checkOutput("small_we", 32'(bus_s.mem_we), 32'd0);
    checkOutput("small_accepted", 32'(acc), 32'd4);

    // Reset while a write is stalled, then reload from BASE_ADDR.
    @(negedge clk); start_s = 1'b1; bus_s.in_valid = 1'b0; bus_s.mem_ack = 1'b0;
    @(negedge clk); start_s = 1'b0; driveSmall(small_t[2]); bus_s.in_valid = 1'b1;
    @(negedge clk); bus_s.in_valid = 1'b0;
    #1;
    checkOutput("pre_rst_we", 32'(bus_s.mem_we), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_we", 32'(bus_s.mem_we), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus_s.in_ready), 32'd0);
    checkOutput("mid_rst_addr", 32'(bus_s.mem_addr), 32'd0);
    checkOutput("mid_rst_wdata", bus_s.mem_wdata, 32'd0);
    checkOutput("mid_rst_count", 32'(count_s), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy_s), 32'd0);
    checkOutput("mid_rst_full", 32'(full_s), 32'd0);
    checkOutput("mid_rst_err", 32'(err_s), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0; driveSmall(small_t[3]); bus_s.in_valid = 1'b1; bus_s.mem_ack = 1'b1;
    @(negedge clk); bus_s.in_valid = 1'b0;
    #1;
    checkOutput("reload_we", 32'(bus_s.mem_we), 32'd1);
    checkOutput("reload_addr", 32'(bus_s.mem_addr), 32'd0);
    checkOutput("reload_wdata", bus_s.mem_wdata, small_w[3]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
